// File: rtl/frame_color_detect.sv
// Sweeps the stored RGB332 frame once per start request, counts red/green/blue
// pixels and reports the dominant colour once the sweep is complete.
module frame_color_detect #(
  parameter int SCREEN_X  = 160,
  parameter int SCREEN_Y  = 120,
  parameter int AW        = 15,
  parameter int THRESHOLD = 1920
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          busy,
  output logic          done,
  output logic [1:0]    color,
  output logic [AW-1:0] cnt_red,
  output logic [AW-1:0] cnt_green,
  output logic [AW-1:0] cnt_blue
);

  localparam int            NPIX      = SCREEN_X * SCREEN_Y;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [31:0]   THR       = 32'(THRESHOLD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DRAIN  = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'b00,
    CLS_RED   = 2'b01,
    CLS_GREEN = 2'b10,
    CLS_BLUE  = 2'b11
  } cls_t;

  state_t        state;
  logic          valid;
  cls_t          pix_cls;
  cls_t          win_cls;
  logic [AW-1:0] win_cnt;
  logic [1:0]    dec_color;

  logic [2:0] pix_r, pix_g;
  logic [1:0] pix_b;

  assign pix_r = mem_data[7:5];
  assign pix_g = mem_data[4:2];
  assign pix_b = mem_data[1:0];

  // The three colour classes have disjoint field ranges, so at most one matches.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // pix_cls unassigned, which would otherwise infer a latch.
    pix_cls = CLS_NONE;
    if (pix_r >= 3'd5 && pix_g <= 3'd3 && pix_b <= 2'd1)
      pix_cls = CLS_RED;
    else if (pix_g >= 3'd5 && pix_r <= 3'd3 && pix_b <= 2'd1)
      pix_cls = CLS_GREEN;
    else if (pix_b == 2'd3 && pix_r <= 3'd3 && pix_g <= 3'd3)
      pix_cls = CLS_BLUE;
  end

  // Strict greater-than keeps the earlier colour on ties: red > green > blue.
  always_comb begin
    win_cls = CLS_RED;
    win_cnt = cnt_red;
    if (cnt_green > win_cnt) begin
      win_cls = CLS_GREEN;
      win_cnt = cnt_green;
    end
    if (cnt_blue > win_cnt) begin
      win_cls = CLS_BLUE;
      win_cnt = cnt_blue;
    end
    dec_color = ({{(32-AW){1'b0}}, win_cnt} >= THR) ? win_cls : CLS_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      color     <= CLS_NONE;
      valid     <= 1'b0;
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others regardless of statement order.
      done  <= 1'b0;
      valid <= (state == READ);

      case (state)
        IDLE: begin
          mem_addr <= '0;
          if (start) begin
            state     <= READ;
            busy      <= 1'b1;
            cnt_red   <= '0;
            cnt_green <= '0;
            cnt_blue  <= '0;
          end
        end
        READ: begin
          if (mem_addr == LAST_ADDR) begin
            state    <= DRAIN;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + AW'(1);
          end
        end
        DRAIN:  state <= DECIDE;
        DECIDE: begin
          state <= DONE;
          color <= dec_color;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Data returned for the previous READ address; never set while IDLE,
      // so it cannot collide with the clear on start.
      if (valid) begin
        case (pix_cls)
          CLS_RED:   cnt_red   <= cnt_red + AW'(1);
          CLS_GREEN: cnt_green <= cnt_green + AW'(1);
          CLS_BLUE:  cnt_blue  <= cnt_blue + AW'(1);
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_color_detect.sv
// Directed bench for frame_color_detect: two instances (threshold 3 and 4)
// read one shared frame model; expected results go through a scoreboard queue.
module tb_frame_color_detect;

  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [7:0]    mem_data_a, mem_data_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [1:0]    color_a, color_b;
  logic [AW-1:0] cnt_red_a, cnt_green_a, cnt_blue_a;
  logic [AW-1:0] cnt_red_b, cnt_green_b, cnt_blue_b;

  logic [7:0] mem [8];

  typedef struct {
    logic [AW-1:0] r, g, b;
    logic [1:0]    ca, cb;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  logic [1:0] prev_ca, prev_cb;

  int total = 0;
  int bad   = 0;

  frame_color_detect #(.SCREEN_X(4), .SCREEN_Y(2), .AW(AW), .THRESHOLD(3)) u_a (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .busy(busy_a), .done(done_a), .color(color_a),
    .cnt_red(cnt_red_a), .cnt_green(cnt_green_a), .cnt_blue(cnt_blue_a)
  );

  frame_color_detect #(.SCREEN_X(4), .SCREEN_Y(2), .AW(AW), .THRESHOLD(4)) u_b (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .busy(busy_b), .done(done_b), .color(color_b),
    .cnt_red(cnt_red_b), .cnt_green(cnt_green_b), .cnt_blue(cnt_blue_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read frame buffer model.
  always @(posedge clk) begin
    mem_data_a <= mem[mem_addr_a[2:0]];
    mem_data_b <= mem[mem_addr_b[2:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input logic [7:0] px);
    int r, g, b;
    r = int'(px[7:5]);
    g = int'(px[4:2]);
    b = int'(px[1:0]);
    if (r >= 5 && g <= 3 && b <= 1) return 2'b01;
    if (g >= 5 && r <= 3 && b <= 1) return 2'b10;
    if (b == 3 && r <= 3 && g <= 3) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] pick(input int r, input int g, input int b, input int thr);
    int best;
    logic [1:0] code;
    best = r; code = 2'b01;
    if (g > best) begin best = g; code = 2'b10; end
    if (b > best) begin best = b; code = 2'b11; end
    return (best >= thr) ? code : 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int r, g, b;
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 8; i++) begin
      case (classify(mem[i]))
        2'b01:   r++;
        2'b10:   g++;
        2'b11:   b++;
        default: ;
      endcase
    end
    e.r  = AW'(r);
    e.g  = AW'(g);
    e.b  = AW'(b);
    e.ca = pick(r, g, b, 3);
    e.cb = pick(r, g, b, 4);
    return e;
  endfunction

  task automatic load(input logic [63:0] frame);
    for (int i = 0; i < 8; i++) mem[i] = frame[63 - 8*i -: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_a"}, mem_addr_a, 0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_color_a"}, color_a, 0);
    check({tag, "_cnts_a"}, {cnt_red_a, cnt_green_a, cnt_blue_a}, 0);
    check({tag, "_color_b"}, color_b, 0);
    check({tag, "_cnts_b"}, {cnt_red_b, cnt_green_b, cnt_blue_b}, 0);
  endtask

  // One start pulse and a 14-cycle observation window. extra_start pulses start
  // again in that cycle; rst_cycle asserts reset in that cycle (0 = none).
  task automatic sweep(input string tag, input int extra_start, input int rst_cycle);
    exp_t e;
    int done_seen;
    done_seen = 0;
    if (rst_cycle == 0) sb.push_back(model());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      start = (n == extra_start);
      if (n == rst_cycle) rst = 1'b0;
      if (rst_cycle != 0 && n == rst_cycle + 2) rst = 1'b1;
      @(negedge clk);
      if (rst_cycle != 0 && n >= rst_cycle) begin
        if (n == rst_cycle) begin
          prev_ca = 2'b00;
          prev_cb = 2'b00;
          check_reset_outputs({tag, "_rst"});
        end
        check({tag, "_busy_after_rst"}, busy_a, 0);
        check({tag, "_done_after_rst"}, done_a, 0);
      end else begin
        if (n <= 8) check($sformatf("%s_addr_c%0d", tag, n), mem_addr_a, n - 1);
        if (n == 9) check({tag, "_addr_drain"}, mem_addr_a, 0);
        if (n == 1) check({tag, "_cnt_clear"}, {cnt_red_a, cnt_green_a, cnt_blue_a}, 0);
        check($sformatf("%s_busy_c%0d", tag, n), busy_a, (n <= 10) ? 1 : 0);
        check($sformatf("%s_done_c%0d", tag, n), done_a, (n == 11) ? 1 : 0);
        check($sformatf("%s_doneb_c%0d", tag, n), done_b, (n == 11) ? 1 : 0);
        if (n <= 10) begin
          check($sformatf("%s_color_hold_c%0d", tag, n), color_a, prev_ca);
          check($sformatf("%s_colorb_hold_c%0d", tag, n), color_b, prev_cb);
        end
        if (done_a === 1'b1) begin
          done_seen++;
          check({tag, "_sb_nonempty"}, (sb.size() != 0) ? 1 : 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_cnt_red_a"}, cnt_red_a, e.r);
            check({tag, "_cnt_green_a"}, cnt_green_a, e.g);
            check({tag, "_cnt_blue_a"}, cnt_blue_a, e.b);
            check({tag, "_color_a"}, color_a, e.ca);
            check({tag, "_cnts_b"}, {cnt_red_b, cnt_green_b, cnt_blue_b}, {e.r, e.g, e.b});
            check({tag, "_color_b"}, color_b, e.cb);
            last_exp = e;
            prev_ca  = e.ca;
            prev_cb  = e.cb;
          end
        end
        if (n == 13) begin
          check({tag, "_cnts_hold"}, {cnt_red_a, cnt_green_a, cnt_blue_a},
                {last_exp.r, last_exp.g, last_exp.b});
          check({tag, "_color_hold_after"}, color_a, last_exp.ca);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_count"}, done_seen, (rst_cycle == 0) ? 1 : 0);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    prev_ca = 2'b00;
    prev_cb = 2'b00;
    load(64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("idle");

    load(64'hE0E0_E0E0_1C1C_0300);
    sweep("mixed", 0, 0);

    load(64'h9292_9292_9292_9292);
    sweep("grey", 0, 0);

    load(64'h1C1C_1C03_0303_9200);
    sweep("tie", 0, 0);

    load(64'hE0E0_E0E0_1C1C_0300);
    sweep("restart_ignored", 4, 0);

    sweep("reset_mid", 0, 5);

    load(64'h1C1C_1C03_0303_9200);
    sweep("after_reset", 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
